// File: rtl/axi_node_pkg.sv
// axi_node_pkg: shared R-path types, default sizes and the port-index helper
// used by the AXI node read-return logic.
package axi_node_pkg;

    localparam int NODE_DATA_W         = 64;
    localparam int NODE_USER_W         = 6;
    localparam int NODE_N_TARG         = 7;
    localparam int NODE_LOG_N_TARG     = $clog2(NODE_N_TARG);
    localparam int NODE_ID_IN          = 16;
    localparam int NODE_ID_OUT         = NODE_ID_IN + NODE_LOG_N_TARG;
    localparam int MAX_OUTSTANDING_DEF = 8;

    // One R beat as it travels through the router (ID still carries the port index).
    typedef struct packed {
        logic [NODE_ID_OUT-1:0] id;
        logic [NODE_DATA_W-1:0] data;
        logic [1:0]             resp;
        logic                   last;
        logic [NODE_USER_W-1:0] user;
    } r_payload_t;

    // The AR allocation stage prepends the target-port index above the original ID.
    function automatic logic [NODE_LOG_N_TARG-1:0] port_index(input logic [NODE_ID_OUT-1:0] id);
        return id[NODE_ID_OUT-1:NODE_ID_IN];
    endfunction

endpackage

// File: rtl/axi_R_skid_buffer.sv
// axi_R_skid_buffer: generic 2-entry valid/ready slice. in_ready is a pure
// register output, so no combinational path exists from out_ready to in_ready.
module axi_R_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_r, out_valid_nxt_s;
    logic [WIDTH-1:0] out_data_r, out_data_nxt_s;
    logic             skid_valid_r, skid_valid_nxt_s;
    logic [WIDTH-1:0] skid_data_r, skid_data_nxt_s;
    logic             in_ready_r;
    logic             in_hs_s;

    assign in_hs_s   = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Next-state: refill the output slot (skid entry first), park a beat in skid when stalled.
    always_comb begin
        out_valid_nxt_s  = out_valid_r;
        out_data_nxt_s   = out_data_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        if (!out_valid_r || out_ready) begin
            if (skid_valid_r) begin
                out_valid_nxt_s  = 1'b1;
                out_data_nxt_s   = skid_data_r;
                skid_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = in_hs_s;
                out_data_nxt_s  = in_hs_s ? in_data : out_data_r;
            end
        end else begin
            if (in_hs_s) begin
                skid_valid_nxt_s = 1'b1;
                skid_data_nxt_s  = in_data;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // State register; ready is low in reset and follows skid occupancy afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            out_data_r   <= out_data_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
        end
    end

endmodule

// File: rtl/axi_r_router.sv
// axi_r_router: routes R beats to the originating target port (index taken from
// the upper ID bits), strips the index, and tracks per-port outstanding bursts.
// Build option: AXI_R_ROUTER_SKID_EN inserts a 2-entry skid buffer on the input
// (registered rready_o, 1-cycle latency); otherwise the path is combinational.
module axi_r_router
    import axi_node_pkg::*;
#(
    parameter int AXI_DATA_W      = NODE_DATA_W,
    parameter int AXI_USER_W      = NODE_USER_W,
    parameter int N_TARG_PORT     = NODE_N_TARG,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN       = NODE_ID_IN,
    parameter int AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ar_valid_i,
    input  logic                              ar_ready_i,
    input  logic [AXI_ID_OUT-1:0]             ar_id_i,
    output logic [N_TARG_PORT-1:0]            ar_stall_o,
    input  logic [AXI_ID_OUT-1:0]             rid_i,
    input  logic [AXI_DATA_W-1:0]             rdata_i,
    input  logic [1:0]                        rresp_i,
    input  logic                              rlast_i,
    input  logic [AXI_USER_W-1:0]             ruser_i,
    input  logic                              rvalid_i,
    output logic                              rready_o,
    output logic [N_TARG_PORT*AXI_ID_IN-1:0]  rid_o,
    output logic [N_TARG_PORT*AXI_DATA_W-1:0] rdata_o,
    output logic [N_TARG_PORT*2-1:0]          rresp_o,
    output logic [N_TARG_PORT-1:0]            rlast_o,
    output logic [N_TARG_PORT*AXI_USER_W-1:0] ruser_o,
    output logic [N_TARG_PORT-1:0]            rvalid_o,
    input  logic [N_TARG_PORT-1:0]            rready_i,
    output logic                              err_o
);

    localparam int                    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [LOG_N_TARG:0]   N_PORTS = (LOG_N_TARG + 1)'(N_TARG_PORT);

    r_payload_t            in_pl_s, head_pl_s;
    logic                  head_valid_s, head_ready_s, hit_ready_s;
    logic [LOG_N_TARG-1:0] sel_s, ar_sel_s;
    logic                  sel_ok_s, ar_fire_s, err_evt_s;
    logic [N_TARG_PORT-1:0] inc_s, dec_s;
    logic [CNT_W-1:0]      cnt_r     [N_TARG_PORT];
    logic [CNT_W-1:0]      cnt_nxt_s [N_TARG_PORT];
    logic [N_TARG_PORT-1:0] ar_stall_r;
    logic                  err_r;
    logic                  ar_id_unused_s;

    assign in_pl_s = '{id: rid_i, data: rdata_i, resp: rresp_i, last: rlast_i, user: ruser_i};

`ifdef AXI_R_ROUTER_SKID_EN
    logic [$bits(r_payload_t)-1:0] head_data_s;

    axi_R_skid_buffer #(
        .WIDTH ($bits(r_payload_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rvalid_i),
        .in_ready  (rready_o),
        .in_data   (in_pl_s),
        .out_valid (head_valid_s),
        .out_ready (head_ready_s),
        .out_data  (head_data_s)
    );
    assign head_pl_s = r_payload_t'(head_data_s);
`else
    assign head_valid_s = rvalid_i;
    assign head_pl_s    = in_pl_s;
    assign rready_o     = head_ready_s;
`endif

    assign sel_s    = port_index(head_pl_s.id);
    assign sel_ok_s = ({1'b0, sel_s} < N_PORTS);

    // Payload is broadcast; only the selected port sees valid.
    assign rid_o   = {N_TARG_PORT{head_pl_s.id[AXI_ID_IN-1:0]}};
    assign rdata_o = {N_TARG_PORT{head_pl_s.data}};
    assign rresp_o = {N_TARG_PORT{head_pl_s.resp}};
    assign rlast_o = {N_TARG_PORT{head_pl_s.last}};
    assign ruser_o = {N_TARG_PORT{head_pl_s.user}};

    // Steer head valid to the selected port; out-of-range beats are swallowed.
    always_comb begin
        rvalid_o    = '0;
        hit_ready_s = 1'b0;
        for (int p = 0; p < N_TARG_PORT; p++) begin
            if (sel_ok_s && (sel_s == LOG_N_TARG'(p))) begin
                rvalid_o[p] = head_valid_s;
                hit_ready_s = rready_i[p];
            end else begin
                rvalid_o[p] = 1'b0;
            end
        end
        head_ready_s = sel_ok_s ? hit_ready_s : 1'b1;
    end

    assign ar_fire_s      = ar_valid_i & ar_ready_i;
    assign ar_sel_s       = port_index(ar_id_i);
    assign ar_id_unused_s = ^ar_id_i[AXI_ID_IN-1:0];

    // Per-port increment on AR handshake, decrement on a delivered last beat.
    always_comb begin
        for (int p = 0; p < N_TARG_PORT; p++) begin
            inc_s[p] = ar_fire_s && (ar_sel_s == LOG_N_TARG'(p));
            dec_s[p] = rvalid_o[p] && rready_i[p] && head_pl_s.last;
        end
    end

    // Counter next-state with saturation/underflow guards feeding the sticky error.
    always_comb begin
        err_evt_s = 1'b0;
        for (int p = 0; p < N_TARG_PORT; p++) begin
            cnt_nxt_s[p] = cnt_r[p];
            case ({inc_s[p], dec_s[p]})
                2'b10: begin
                    if (cnt_r[p] == MAX_CNT) begin
                        err_evt_s = 1'b1;
                    end else begin
                        cnt_nxt_s[p] = cnt_r[p] + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (cnt_r[p] == '0) begin
                        err_evt_s = 1'b1;
                    end else begin
                        cnt_nxt_s[p] = cnt_r[p] - CNT_W'(1);
                    end
                end
                default: cnt_nxt_s[p] = cnt_r[p];
            endcase
        end
        if (head_valid_s && !sel_ok_s) begin
            err_evt_s = 1'b1;
        end else begin
            err_evt_s = err_evt_s;
        end
    end

    // Counters, registered stall hints and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N_TARG_PORT; p++) begin
                cnt_r[p] <= '0;
            end
            ar_stall_r <= '0;
            err_r      <= 1'b0;
        end else begin
            for (int p = 0; p < N_TARG_PORT; p++) begin
                cnt_r[p]      <= cnt_nxt_s[p];
                ar_stall_r[p] <= (cnt_nxt_s[p] == MAX_CNT);
            end
            err_r <= err_r | err_evt_s;
        end
    end

    assign ar_stall_o = ar_stall_r;
    assign err_o      = err_r;

endmodule

// File: doc/axi_r_router.md
# axi_R_router

Read-response return stage for one master port of the AXI node. It consumes the R channel coming back from a slave, whose IDs carry the binary target-port index in the upper bits added by the AR allocation stage. It strips that index, routes each beat to the originating target port, and tracks per-port outstanding read bursts. The tracking provides a back-pressure hint to the AR path.

## Interface
- AXI_DATA_W, 64: R data width
- AXI_USER_W, 6: R user width
- N_TARG_PORT, 7: number of target (slave-side) ports
- LOG_N_TARG, $clog2(N_TARG_PORT): index width
- AXI_ID_IN, 16: per-port ID width
- AXI_ID_OUT, AXI_ID_IN+LOG_N_TARG: extended ID width
- MAX_OUTSTANDING, 8: max open read bursts per target port
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ar_valid_i  in  1  AR valid on the downstream (allocated) side
- ar_ready_i  in  1  AR ready on the same side
- ar_id_i  in  AXI_ID_OUT  AR ID; bits [AXI_ID_OUT-1:AXI_ID_IN] hold the port index
- ar_stall_o  out  N_TARG_PORT  port has reached MAX_OUTSTANDING
- rid_i  in  AXI_ID_OUT  incoming R ID
- rdata_i  in  AXI_DATA_W  incoming read data
- rresp_i  in  2  incoming response
- rlast_i  in  1  incoming last beat
- ruser_i  in  AXI_USER_W  incoming user
- rvalid_i  in  1  incoming valid
- rready_o  out  1  incoming ready
- rid_o  out  N_TARG_PORT×AXI_ID_IN  per-port ID (index stripped)
- rdata_o  out  N_TARG_PORT×AXI_DATA_W  per-port data (broadcast)
- rresp_o  out  N_TARG_PORT×2  per-port response
- rlast_o  out  N_TARG_PORT  per-port last
- ruser_o  out  N_TARG_PORT×AXI_USER_W  per-port user
- rvalid_o  out  N_TARG_PORT  per-port valid, at most one bit set
- rready_i  in  N_TARG_PORT  per-port ready
- err_o  out  1  sticky protocol error

## Operation
- Port select: sel = rid[AXI_ID_OUT-1:AXI_ID_IN] of the head beat. rvalid_o[sel] = head valid. Data, ID, resp, last and user are broadcast to all ports.
- sel ≥ N_TARG_PORT: the beat is consumed (accepted internally), no rvalid_o is raised, and err_o is set.
- Outstanding counters: one per port, width $clog2(MAX_OUTSTANDING+1).
  - Increment when ar_valid_i & ar_ready_i, for the port index in ar_id_i.
  - Decrement when a beat with rlast is handed to the port (rvalid_o[p] & rready_i[p] & rlast_o[p]).
- Same port incremented and decremented in the same cycle: count unchanged. Different ports: both update.
- ar_stall_o[p] = (count[p] == MAX_OUTSTANDING), driven from registers.
- Increment while count == MAX_OUTSTANDING: count saturates and err_o is set.
- Decrement while count == 0: count stays 0, err_o is set, and the beat is still delivered.
- err_o clears only on rst.
- Non-last beats never change a counter.
- Beat order is preserved globally.
- No interleaving rules are enforced. Routing is per beat.

## Timing
- Reset values: rvalid_o = 0, rready_o = 0, ar_stall_o = 0, err_o = 0, counters = 0, buffer empty.
- rready_o = 1 from the first cycle after rst deasserts (skid build).
- Skid build: latency 1 cycle from input handshake to rvalid_o. Sustains 1 beat per cycle when the selected port is ready every cycle.
- Skid build: rready_o is a register output with no combinational path from rready_i.
- Pass-through build: latency 0 cycles. rready_o = rready_i[sel], or 1 when sel is out of range.
- rvalid_o[p] with its payload is held stable until rready_i[p]. Per-port rvalid_o never drops without a handshake.
- ar_stall_o updates the cycle after the counter edge.
- rst mid-burst: all state cleared immediately. The in-flight beats are lost, which is the intended behaviour.

## Configuration
- AXI_R_ROUTER_SKID_EN defined: a 2-entry skid buffer sits on the input, with the registered rready_o and 1-cycle latency described above.
- AXI_R_ROUTER_SKID_EN undefined: combinational pass-through with zero latency. Counters and error logic are identical in both builds.

## Structure
- Shared package axi_node_pkg holds:
  - the typedef for the R payload struct (data, resp, last, user, id)
  - the port-index extraction function
  - the MAX_OUTSTANDING default
- Sub-module axi_R_skid_buffer: generic 2-entry valid/ready slice over the R payload. Instantiated only under AXI_R_ROUTER_SKID_EN.

## Test plan
- AR issued with ar_id_i index 3, then 4 R beats with rid index 3 and rlast on beat 4 → rvalid_o[3] only; rid_o carries the lower 16 bits; count[3] goes 0→1→0.
- 8 ARs to port 0 with no R traffic → ar_stall_o[0] = 1 the cycle after the 8th. A 9th AR → err_o = 1 and count stays 8.
- Port 2 rready_i held low 5 cycles with a beat pending → rvalid_o[2] and payload stable for all 5 cycles; rready_o = 0 after the buffer fills (skid build).
- Back-to-back single-beat bursts alternating ports 1 and 5, all ready → 1 beat/cycle throughput with order preserved.
- rid index 7 with N_TARG_PORT = 7 → beat consumed, no rvalid_o raised, err_o = 1. rlast to port 6 with count 0 → beat delivered, err_o = 1.
- rst asserted mid-burst with count[2] = 3 → the next cycle has all outputs at reset values and count[2] = 0.
